// File: rtl/row_reducer_scheduler.sv
// Feeds per-patch-row config words into a pool of row reducers, one init strobe per load,
// tracking reducer occupancy and frame-level errors in the camera-link clock domain.
module row_reducer_scheduler #(
  parameter int unsigned N_ROW_REDUCER = 10,
  parameter int unsigned CFG_WIDTH     = 256,
  parameter int unsigned N_ROW_SIZE    = 11
) (
  input  logic                     clk_85,
  input  logic                     reset,
  input  logic                     cl_fval,
  input  logic                     cl_lval,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [CFG_WIDTH-1:0]     cfg_data,
  input  logic [N_ROW_SIZE-1:0]    cfg_row,
  input  logic                     cfg_last,
  output logic [N_ROW_REDUCER-1:0] row_init,
  output logic [CFG_WIDTH-1:0]     config_data,
  input  logic [N_ROW_REDUCER-1:0] row_done,
  output logic [N_ROW_REDUCER-1:0] busy,
  output logic [N_ROW_SIZE-1:0]    cur_row,
  output logic                     late_err,
  output logic                     overflow,
  output logic                     frame_done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    FLUSH     = 3'd2,
    WAIT_FEND = 3'd3,
    DRAIN     = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic fval_d, lval_d, pend_drop;
  logic fval_rise, fval_fall, lval_rise, lval_fall;
  logic [N_ROW_REDUCER-1:0] free_oh;
  logic free_any, row_match;
  logic issue_c, drop_c, flag_late_c, flag_ovf_c, frame_end_c, rise_pend_c;

  assign fval_rise = cl_fval & ~fval_d;
  assign fval_fall = ~cl_fval & fval_d;
  assign lval_rise = cl_lval & ~lval_d;
  assign lval_fall = ~cl_lval & lval_d;

  // Lowest clear bit of busy, isolated as a one-hot mask.
  assign free_oh   = ~busy & (busy + N_ROW_REDUCER'(1));
  assign free_any  = ~&busy;
  assign row_match = (cfg_row == cur_row);

  assign cfg_ready = issue_c | drop_c;

  always_ff @(posedge clk_85 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state, handshake and flag decode.
  always_comb begin
    state_nxt   = state;
    issue_c     = 1'b0;
    drop_c      = 1'b0;
    flag_late_c = 1'b0;
    flag_ovf_c  = 1'b0;
    frame_end_c = 1'b0;
    rise_pend_c = 1'b0;
    case (state)
      IDLE: begin
        if (fval_rise) state_nxt = LOAD;
      end
      LOAD: begin
        if (!cl_lval && cfg_valid && row_match && free_any) begin
          issue_c = 1'b1;
        end else if (cfg_valid && (cfg_row < cur_row)) begin
          drop_c      = 1'b1;
          flag_late_c = 1'b1;
        end else if (cfg_valid && pend_drop) begin
          drop_c = 1'b1;
        end
        // A word still waiting for its row when the line starts has missed its gap.
        if (lval_rise && cfg_valid && row_match) begin
          rise_pend_c = 1'b1;
          if (&busy) flag_ovf_c  = 1'b1;
          else       flag_late_c = 1'b1;
        end
        if ((issue_c || drop_c) && cfg_last) begin
          state_nxt = fval_fall ? DRAIN : WAIT_FEND;
        end else if (fval_fall) begin
          state_nxt   = FLUSH;
          flag_late_c = 1'b1;
        end
      end
      FLUSH: begin
        if (cfg_valid) begin
          drop_c = 1'b1;
          if (cfg_last) state_nxt = DRAIN;
        end
      end
      WAIT_FEND: begin
        if (fval_fall) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (fval_rise) flag_ovf_c = 1'b1;
        if (busy == '0) begin
          frame_end_c = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered datapath, occupancy, row counter and sticky flags.
  always_ff @(posedge clk_85 or posedge reset) begin
    if (reset) begin
      fval_d      <= 1'b0;
      lval_d      <= 1'b0;
      pend_drop   <= 1'b0;
      row_init    <= '0;
      config_data <= '0;
      busy        <= '0;
      cur_row     <= '0;
      late_err    <= 1'b0;
      overflow    <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      fval_d     <= cl_fval;
      lval_d     <= cl_lval;
      pend_drop  <= rise_pend_c;
      row_init   <= issue_c ? free_oh : '0;
      if (issue_c) config_data <= cfg_data;
      busy       <= (busy & ~row_done) | (issue_c ? free_oh : '0);
      if (fval_rise)      cur_row <= '0;
      else if (lval_fall) cur_row <= cur_row + N_ROW_SIZE'(1);
      late_err   <= late_err | flag_late_c;
      overflow   <= overflow | flag_ovf_c;
      frame_done <= frame_end_c;
    end
  end

endmodule

// File: tb/tb_row_reducer_scheduler.sv
// Directed bench for row_reducer_scheduler: normal frame, late drop, mid-row reset,
// fval-fall flush and reducer-pool overflow, with hand-computed expectations.
module tb_row_reducer_scheduler;

  localparam int unsigned NR = 10;
  localparam int unsigned CW = 256;
  localparam int unsigned RS = 11;

  logic          clk_85;
  logic          reset;
  logic          cl_fval, cl_lval;
  logic          cfg_valid, cfg_ready, cfg_last;
  logic [CW-1:0] cfg_data, config_data;
  logic [RS-1:0] cfg_row, cur_row;
  logic [NR-1:0] row_init, row_done, busy;
  logic          late_err, overflow, frame_done;

  int errors = 0;
  int checks = 0;

  row_reducer_scheduler #(.N_ROW_REDUCER(NR), .CFG_WIDTH(CW), .N_ROW_SIZE(RS)) dut (
    .clk_85(clk_85), .reset(reset), .cl_fval(cl_fval), .cl_lval(cl_lval),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .cfg_row(cfg_row), .cfg_last(cfg_last), .row_init(row_init),
    .config_data(config_data), .row_done(row_done), .busy(busy),
    .cur_row(cur_row), .late_err(late_err), .overflow(overflow),
    .frame_done(frame_done)
  );

  initial begin
    clk_85 = 1'b0;
    forever #5 clk_85 = ~clk_85;
  end

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_85);
    #1;
  endtask

  function automatic logic [CW-1:0] dat(input int k);
    return CW'(32'hD00D_0000) + CW'(k);
  endfunction

  task automatic put(input logic [RS-1:0] row, input logic last, input logic [CW-1:0] d);
    cfg_valid = 1'b1;
    cfg_row   = row;
    cfg_last  = last;
    cfg_data  = d;
    #1;
  endtask

  task automatic lval_pulse(input int len);
    cl_lval = 1'b1;
    cyc(len);
    cl_lval = 1'b0;
    cyc(1);
  endtask

  initial begin
    logic [NR-1:0] exp_oh;
    reset = 1'b1; cl_fval = 1'b0; cl_lval = 1'b0; cfg_valid = 1'b0;
    cfg_data = '0; cfg_row = '0; cfg_last = 1'b0; row_done = '0;
    cyc(2);
    cfg_valid = 1'b1; #1;
    check("rst_busy", CW'(busy), CW'(0));
    check("rst_row_init", CW'(row_init), CW'(0));
    check("rst_cur_row", CW'(cur_row), CW'(0));
    check("rst_flags", CW'({late_err, overflow, frame_done}), CW'(0));
    check("rst_config_data", config_data, CW'(0));
    check("idle_ready", CW'(cfg_ready), CW'(0));
    cfg_valid = 1'b0; reset = 1'b0; cyc(1);

    // Frame 1: rows 0,0,1,1,2,2(last) with reducers returned between rows
    cl_fval = 1'b1; cyc(1);
    put(0, 1'b0, dat(0)); check("f1_ready_a", CW'(cfg_ready), CW'(1));
    cyc(1);
    check("f1_init_a", CW'(row_init), CW'(10'h001));
    check("f1_data_a", config_data, dat(0));
    put(0, 1'b0, dat(1)); check("f1_ready_b", CW'(cfg_ready), CW'(1));
    cyc(1);
    check("f1_init_b", CW'(row_init), CW'(10'h002));
    check("f1_busy_b", CW'(busy), CW'(10'h003));
    put(1, 1'b0, dat(2)); check("f1_early_hold", CW'(cfg_ready), CW'(0));
    cyc(1);
    check("f1_init_one_cycle", CW'(row_init), CW'(0));
    lval_pulse(3);
    check("f1_cur_row1", CW'(cur_row), CW'(1));
    check("f1_ready_c", CW'(cfg_ready), CW'(1));
    cyc(1);
    check("f1_init_c", CW'(row_init), CW'(10'h004));
    check("f1_data_c", config_data, dat(2));
    put(1, 1'b0, dat(3)); row_done = 10'h001;
    cyc(1); row_done = '0;
    check("f1_init_d", CW'(row_init), CW'(10'h008));
    check("f1_busy_d", CW'(busy), CW'(10'h00E));
    put(2, 1'b0, dat(4)); check("f1_hold_e", CW'(cfg_ready), CW'(0));
    lval_pulse(3);
    check("f1_ready_e", CW'(cfg_ready), CW'(1));
    cyc(1);
    check("f1_init_reuse", CW'(row_init), CW'(10'h001));
    put(2, 1'b1, dat(5)); cyc(1);
    check("f1_init_last", CW'(row_init), CW'(10'h010));
    check("f1_busy_last", CW'(busy), CW'(10'h01F));
    put(3, 1'b0, dat(6)); check("f1_wait_fend_ready", CW'(cfg_ready), CW'(0));
    cfg_valid = 1'b0; cfg_last = 1'b0;
    lval_pulse(3);
    cl_fval = 1'b0; cyc(1);
    check("f1_no_done_busy", CW'(frame_done), CW'(0));
    row_done = 10'h01F; cyc(1); row_done = '0;
    check("f1_busy_drained", CW'(busy), CW'(0));
    check("f1_done_lat", CW'(frame_done), CW'(0));
    cyc(1);
    check("f1_frame_done", CW'(frame_done), CW'(1));
    cyc(1);
    check("f1_frame_done_pulse", CW'(frame_done), CW'(0));
    check("f1_no_errors", CW'({late_err, overflow}), CW'(0));

    // Frame 2: late word dropped, then reset while reducers are busy
    cl_fval = 1'b1; cyc(1);
    lval_pulse(2);
    put(0, 1'b0, dat(7)); check("f2_late_ready", CW'(cfg_ready), CW'(1));
    cyc(1); cfg_valid = 1'b0;
    check("f2_late_err", CW'(late_err), CW'(1));
    check("f2_late_no_init", CW'(row_init), CW'(0));
    for (int i = 0; i < 4; i++) begin
      put(1, 1'b0, dat(8 + i)); cyc(1);
    end
    cfg_valid = 1'b0;
    check("f2_pre_rst_busy", CW'(busy), CW'(10'h00F));
    check("f2_pre_rst_init", CW'(row_init), CW'(10'h008));
    reset = 1'b1; #1;
    check("f2_rst_busy", CW'(busy), CW'(0));
    check("f2_rst_init", CW'(row_init), CW'(0));
    check("f2_rst_cur_row", CW'(cur_row), CW'(0));
    check("f2_rst_late", CW'(late_err), CW'(0));
    check("f2_rst_data", config_data, CW'(0));
    cl_fval = 1'b0; cyc(2); reset = 1'b0; cyc(1);

    // Frame 3: clean load after reset, then fval falls with words outstanding
    cl_fval = 1'b1; cyc(1);
    put(0, 1'b0, dat(20)); check("f3_ready", CW'(cfg_ready), CW'(1));
    cyc(1);
    check("f3_init", CW'(row_init), CW'(10'h001));
    put(5, 1'b0, dat(21)); check("f3_future_hold", CW'(cfg_ready), CW'(0));
    cl_fval = 1'b0; cyc(1);
    check("f3_flush_late", CW'(late_err), CW'(1));
    check("f3_flush_w0", CW'(cfg_ready), CW'(1));
    cyc(1);
    put(0, 1'b0, dat(22)); check("f3_flush_w1", CW'(cfg_ready), CW'(1));
    cyc(1);
    put(9, 1'b1, dat(23)); check("f3_flush_w2", CW'(cfg_ready), CW'(1));
    cyc(1); cfg_valid = 1'b0; cfg_last = 1'b0;
    check("f3_flush_no_init", CW'(row_init), CW'(0));
    check("f3_busy_held", CW'(busy), CW'(10'h001));
    cyc(2);
    check("f3_wait_busy", CW'(frame_done), CW'(0));
    row_done = 10'h001; cyc(1); row_done = '0;
    cyc(1);
    check("f3_frame_done", CW'(frame_done), CW'(1));

    // Frame 4: eleven row-0 words with no reducer returned
    reset = 1'b1; cyc(1); reset = 1'b0; cyc(1);
    cl_fval = 1'b1; cyc(1);
    for (int i = 0; i < 10; i++) begin
      put(0, 1'b0, dat(30 + i));
      check("f4_ready", CW'(cfg_ready), CW'(1));
      cyc(1);
      exp_oh = NR'(1) << i;
      check("f4_init", CW'(row_init), CW'(exp_oh));
    end
    check("f4_busy_full", CW'(busy), CW'(10'h3FF));
    put(0, 1'b0, dat(40)); check("f4_pool_full_hold", CW'(cfg_ready), CW'(0));
    cl_lval = 1'b1; cyc(1);
    check("f4_overflow", CW'(overflow), CW'(1));
    check("f4_no_late", CW'(late_err), CW'(0));
    check("f4_drop_ready", CW'(cfg_ready), CW'(1));
    cyc(1); cfg_valid = 1'b0;
    check("f4_late_still0", CW'(late_err), CW'(0));
    check("f4_drop_no_init", CW'(row_init), CW'(0));
    cl_lval = 1'b0; cl_fval = 1'b0; cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
